// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable interval timer.
// Holds the control FSM state encoding and the mode encodings.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        DONE    = 2'd2
    } timer_state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Input prescaler: divides the raw increment by (div + 1) and emits pre_tick.
// pre_tick is combinational so a rollover is flagged in the same cycle as increment.
module timer_prescaler #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      hold,
    input  logic                      enable,
    input  logic                      increment,
    input  logic [PRESCALE_WIDTH-1:0] div,
    output logic                      pre_tick
);

    logic [PRESCALE_WIDTH-1:0] pre_cnt_reg;
    logic [PRESCALE_WIDTH-1:0] pre_cnt_next;

    assign pre_tick = enable && increment && (pre_cnt_reg == div);

    // hold (stop) outranks clear (start), which outranks normal counting
    always_comb begin
        pre_cnt_next = pre_cnt_reg;
        if (hold) begin
            pre_cnt_next = pre_cnt_reg;
        end else if (clear) begin
            pre_cnt_next = '0;
        end else if (enable && increment) begin
            pre_cnt_next = pre_tick ? '0 : pre_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_next;
        end
    end

endmodule

// File: rtl/timer_prog.sv
// Runtime-programmable tick timer with prescaler, periodic/one-shot modes and
// full-range modulus (mod_value 0 counts the full 2^BIT_WIDTH states).
module timer_prog
    import timer_pkg::*;
#(
    parameter int BIT_WIDTH      = 16,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      increment,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      mode,
    input  logic [BIT_WIDTH-1:0]      mod_value,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      rolling_over,
    output logic [BIT_WIDTH-1:0]      count,
    output logic                      busy,
    output logic                      done
);

    timer_state_t              state_reg;
    timer_state_t              state_next;
    logic [BIT_WIDTH-1:0]      count_reg;
    logic [BIT_WIDTH-1:0]      count_next;
    logic [BIT_WIDTH-1:0]      shadow_mod_reg;
    logic [PRESCALE_WIDTH-1:0] shadow_prescale_reg;
    logic                      shadow_mode_reg;

    logic                      running;
    logic                      load;
    logic                      pre_tick;
    logic [BIT_WIDTH-1:0]      term;
    logic [BIT_WIDTH-1:0]      term_match;
    logic                      at_term;

    assign running = (state_reg == RUNNING);
    assign load    = start && !stop;

    // Wrapping subtraction: a modulus of 0 yields an all-ones terminal value
    assign term = shadow_mod_reg - 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < BIT_WIDTH; gi++) begin : g_term_cmp
            assign term_match[gi] = ~(count_reg[gi] ^ term[gi]);
        end
    endgenerate

    assign at_term = &term_match;

    timer_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (load),
        .hold     (stop),
        .enable   (running),
        .increment(increment),
        .div      (shadow_prescale_reg),
        .pre_tick (pre_tick)
    );

    assign rolling_over = pre_tick && at_term;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        if (stop) begin
            state_next = IDLE;
        end else if (start) begin
            state_next = RUNNING;
            count_next = '0;
        end else if (rolling_over) begin
            count_next = '0;
            if (shadow_mode_reg == MODE_ONESHOT) begin
                state_next = DONE;
            end
        end else if (pre_tick) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Configuration is only sampled on an accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_mod_reg      <= '0;
            shadow_prescale_reg <= '0;
            shadow_mode_reg     <= MODE_PERIODIC;
        end else if (load) begin
            shadow_mod_reg      <= mod_value;
            shadow_prescale_reg <= prescale;
            shadow_mode_reg     <= mode;
        end
    end

    assign count = count_reg;
    assign busy  = (state_reg == RUNNING);
    assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_timer_prog.sv
// Scoreboard bench for timer_prog (BIT_WIDTH=4, PRESCALE_WIDTH=4): expected
// outputs are pushed when a cycle is driven and compared on the falling edge.
module tb_timer_prog;

    localparam int BW = 4;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          increment;
    logic          start;
    logic          stop;
    logic          mode;
    logic [BW-1:0] mod_value;
    logic [PW-1:0] prescale;
    logic          rolling_over;
    logic [BW-1:0] count;
    logic          busy;
    logic          done;

    timer_prog #(
        .BIT_WIDTH     (BW),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .increment   (increment),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .mod_value   (mod_value),
        .prescale    (prescale),
        .rolling_over(rolling_over),
        .count       (count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] count;
        logic          roll;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    // reference model state: 0 idle, 1 running, 2 done
    int            m_state;
    logic [BW-1:0] m_count;
    logic [PW-1:0] m_pre;
    logic [BW-1:0] m_mod;
    logic [PW-1:0] m_ps;
    logic          m_mode;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_count = '0;
        m_pre   = '0;
        m_mod   = '0;
        m_ps    = '0;
        m_mode  = 1'b0;
    endtask

    task automatic cfg(input logic md, input logic [BW-1:0] mv, input logic [PW-1:0] ps);
        mode      = md;
        mod_value = mv;
        prescale  = ps;
    endtask

    // One clock cycle: inputs are already set (posedge+1), predict, compare at negedge, advance model
    task automatic cycle_one(input logic rs, input logic st, input logic sp, input logic inc);
        exp_t          e;
        exp_t          got;
        logic          pt;
        logic [BW-1:0] term;
        reset     = rs;
        start     = st;
        stop      = sp;
        increment = inc;
        term = m_mod - 4'd1;
        pt   = (m_state == 1) && inc && (m_pre == m_ps);
        e.count = m_count;
        e.roll  = pt && (m_count == term);
        e.busy  = (m_state == 1);
        e.done  = (m_state == 2);
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        $display("cyc=%0d rst=%0b st=%0b sp=%0b inc=%0b count=%0d roll=%0b busy=%0b done=%0b",
                 cyc, rs, st, sp, inc, count, rolling_over, busy, done);
        chk("count", int'(count), int'(got.count));
        chk("rolling_over", int'(rolling_over), int'(got.roll));
        chk("busy", int'(busy), int'(got.busy));
        chk("done", int'(done), int'(got.done));
        if (rs) begin
            model_reset();
        end else if (sp) begin
            m_state = 0;
        end else if (st) begin
            m_mod   = mod_value;
            m_ps    = prescale;
            m_mode  = mode;
            m_count = '0;
            m_pre   = '0;
            m_state = 1;
        end else if (m_state == 1 && inc) begin
            m_pre = pt ? '0 : m_pre + 4'd1;
            if (pt) begin
                if (m_count == term) begin
                    m_count = '0;
                    if (m_mode) m_state = 2;
                end else begin
                    m_count = m_count + 4'd1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n, input logic inc);
        for (int i = 0; i < n; i++) cycle_one(1'b0, 1'b0, 1'b0, inc);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        increment = 1'b0;
        cfg(1'b0, 4'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle_one(1'b1, 1'b0, 1'b0, 1'b1);
        run(2, 1'b1);

        // periodic, mod 5, prescale 0
        cfg(1'b0, 4'd5, 4'd0);
        cycle_one(1'b0, 1'b1, 1'b0, 1'b0);
        run(12, 1'b1);

        // one-shot, mod 3, prescale 2
        cfg(1'b1, 4'd3, 4'd2);
        cycle_one(1'b0, 1'b1, 1'b0, 1'b0);
        run(14, 1'b1);

        // full range
        cfg(1'b0, 4'd0, 4'd0);
        cycle_one(1'b0, 1'b1, 1'b0, 1'b0);
        run(18, 1'b1);

        // stop freezes count at 7, then restart with mod 2
        cfg(1'b0, 4'd10, 4'd0);
        cycle_one(1'b0, 1'b1, 1'b0, 1'b0);
        run(7, 1'b1);
        cycle_one(1'b0, 1'b0, 1'b1, 1'b1);
        run(3, 1'b1);
        cfg(1'b0, 4'd2, 4'd0);
        cycle_one(1'b0, 1'b1, 1'b0, 1'b1);
        run(4, 1'b1);

        // start and stop together: stop wins
        cfg(1'b0, 4'd10, 4'd0);
        cycle_one(1'b0, 1'b1, 1'b0, 1'b0);
        run(3, 1'b1);
        cfg(1'b1, 4'd3, 4'd1);
        cycle_one(1'b0, 1'b1, 1'b1, 1'b1);
        run(2, 1'b1);

        // mid-run reset
        cycle_one(1'b0, 1'b1, 1'b0, 1'b0);
        run(4, 1'b1);
        cycle_one(1'b1, 1'b0, 1'b0, 1'b1);
        run(3, 1'b1);

        // config change while running has no effect
        cfg(1'b0, 4'd4, 4'd0);
        cycle_one(1'b0, 1'b1, 1'b0, 1'b0);
        cfg(1'b1, 4'd9, 4'd3);
        run(10, 1'b1);

        // one-shot to DONE, then restart from DONE with new values
        cfg(1'b1, 4'd2, 4'd0);
        cycle_one(1'b0, 1'b1, 1'b0, 1'b0);
        run(4, 1'b1);
        cfg(1'b0, 4'd9, 4'd0);
        cycle_one(1'b0, 1'b1, 1'b0, 1'b1);
        run(11, 1'b1);

        // modulus 1 with prescale, random increment
        cfg(1'b0, 4'd1, 4'd1);
        cycle_one(1'b0, 1'b1, 1'b0, 1'b0);
        run(6, 1'b1);
        cfg(1'b0, 4'd6, 4'd2);
        cycle_one(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle_one(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));

        if (exp_q.size() != 0) begin
            chk("scoreboard_drain", exp_q.size(), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule
